ena_run_trigger: RTL and testbench



---
 rtl/ena_trig_pkg.sv | 30 +++
 rtl/run_len_counter.sv | 60 ++++++
 rtl/ena_run_trigger.sv | 58 +++++
 tb/tb_ena_run_trigger.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ena_trig_pkg.sv
// Shared constants and helpers for the ena run-length trigger block.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package ena_trig_pkg;

    // Default sizing of the block.
    localparam int DEF_N_CH  = 4;
    localparam int DEF_CNT_W = 4;
    localparam int DEF_EVT_W = 8;

    // The trigger vector is widened to this many bits before the popcount,
    // so N_CH must not exceed POP_W.
    localparam int POP_W   = 32;
    localparam int POP_C_W = 6;

    // Channel counting modes.
    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    // Number of set bits in a trigger vector.
    function automatic logic [POP_C_W-1:0] popcount(input logic [POP_W-1:0] v);
        logic [POP_C_W-1:0] c;
        c = '0;
        for (int i = 0; i < POP_W; i++) begin
            c = c + {{(POP_C_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/run_len_counter.sv
// One channel: counts consecutive high ena samples and pulses when the run hits run_len.
// Latency: trigger is high the cycle after the edge sampling the run_len-th high ena; trigger_d is its next state.
// Backpressure: none, every rising edge is a sample.
module run_len_counter
    import ena_trig_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [CNT_W-1:0] run_len,
    input  logic             mode,
    output logic             trigger_d,
    output logic             trigger
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W:0]   n;
    logic             hit;

    // One extra bit on the incremented count so a saturated counter never aliases onto run_len.
    assign n   = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign hit = (n == {1'b0, run_len});

    // Next-state count and trigger; run_len of zero can never match because n is at least one.
    always_comb begin
        cnt_d     = cnt;
        trigger_d = 1'b0;
        if (!ena) begin
            cnt_d     = '0;
            trigger_d = 1'b0;
        end else if (mode == MODE_ONESHOT) begin
            // Saturate so a long run cannot wrap round and fire a second time.
            cnt_d     = n[CNT_W] ? {CNT_W{1'b1}} : n[CNT_W-1:0];
            trigger_d = hit;
        end else begin
            if (hit) begin
                cnt_d     = '0;
                trigger_d = 1'b1;
            end else begin
                cnt_d     = n[CNT_W-1:0];
                trigger_d = 1'b0;
            end
        end
    end

    // Count and trigger registers; reset discards any run in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            trigger <= 1'b0;
        end else begin
            cnt     <= cnt_d;
            trigger <= trigger_d;
        end
    end

endmodule

// File: rtl/ena_run_trigger.sv
// Multi-channel ena run-length trigger with aggregate OR and wrapping event counter.
// Latency: all outputs registered, one cycle after the sampling edge; no input-to-output combinational path.
// Backpressure: none, every rising edge is a sample.
module ena_run_trigger
    import ena_trig_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int EVT_W = DEF_EVT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  ena,
    input  logic [CNT_W-1:0] run_len,
    input  logic             mode,
    input  logic             evt_clr,
    output logic [N_CH-1:0]  trigger,
    output logic             any_trigger,
    output logic [EVT_W-1:0] evt_cnt
);

    logic [N_CH-1:0]    trig_d;
    logic [POP_C_W-1:0] pop;
    logic [EVT_W-1:0]   evt_d;

    // One independent counter per channel, all sharing run_len and mode.
    for (genvar i = 0; i < N_CH; i++) begin : gen_ch
        run_len_counter #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .ena       (ena[i]),
            .run_len   (run_len),
            .mode      (mode),
            .trigger_d (trig_d[i]),
            .trigger   (trigger[i])
        );
    end

    // Event count adds the pulses being registered this edge; a clear only drops the old total.
    always_comb begin
        pop   = popcount(POP_W'(trig_d));
        evt_d = (evt_clr ? {EVT_W{1'b0}} : evt_cnt) + EVT_W'(pop);
    end

    // Aggregate outputs registered alongside the per-channel triggers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_trigger <= 1'b0;
            evt_cnt     <= '0;
        end else begin
            any_trigger <= |trig_d;
            evt_cnt     <= evt_d;
        end
    end

endmodule

// File: tb/tb_ena_run_trigger.sv
// Self-checking bench for ena_run_trigger: directed scenarios plus randomized stimulus
// compared every cycle against a behavioural channel model.
// Clock period 10, inputs change 1 time unit after each rising edge, outputs sampled there too.
module tb_ena_run_trigger;

    localparam int N_CH  = 4;
    localparam int CNT_W = 4;
    localparam int EVT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk     = 1'b0;
    logic             rst_n   = 1'b0;
    logic [N_CH-1:0]  ena     = '0;
    logic [CNT_W-1:0] run_len = '0;
    logic             mode    = 1'b0;
    logic             evt_clr = 1'b0;
    logic [N_CH-1:0]  trigger;
    logic             any_trigger;
    logic [EVT_W-1:0] evt_cnt;

    int checks = 0;
    int errors = 0;

    // Reference state: run position per channel, expected triggers and event total.
    int              m_cnt [N_CH];
    logic [N_CH-1:0] m_trig;
    int              m_evt;

    ena_run_trigger #(
        .N_CH  (N_CH),
        .CNT_W (CNT_W),
        .EVT_W (EVT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .run_len     (run_len),
        .mode        (mode),
        .evt_clr     (evt_clr),
        .trigger     (trigger),
        .any_trigger (any_trigger),
        .evt_cnt     (evt_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) m_cnt[i] = 0;
        m_trig = '0;
        m_evt  = 0;
    endtask

    // Apply the channel rules to the inputs present at this edge.
    task automatic model_edge();
        int n;
        int k;
        k = 0;
        for (int i = 0; i < N_CH; i++) begin
            if (!ena[i]) begin
                m_cnt[i]  = 0;
                m_trig[i] = 1'b0;
            end else begin
                n = m_cnt[i] + 1;
                if (!mode) begin
                    m_trig[i] = (n == int'(run_len));
                    m_cnt[i]  = (n > CMAX) ? CMAX : n;
                end else if (n == int'(run_len)) begin
                    m_trig[i] = 1'b1;
                    m_cnt[i]  = 0;
                end else begin
                    m_trig[i] = 1'b0;
                    m_cnt[i]  = n % (CMAX + 1);
                end
            end
            if (m_trig[i]) k++;
        end
        m_evt = ((evt_clr ? 0 : m_evt) + k) % (1 << EVT_W);
    endtask

    // One clock: advance the model on the edge, then compare all outputs.
    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        chk("trigger", 32'(trigger), 32'(m_trig));
        chk("any_trigger", 32'(any_trigger), 32'(|m_trig));
        chk("evt_cnt", 32'(evt_cnt), 32'(m_evt));
    endtask

    task automatic clear_evt();
        ena     = '0;
        evt_clr = 1'b1;
        step();
        evt_clr = 1'b0;
    endtask

    initial begin
        int lens [4];
        lens = '{1, 2, 3, 5};
        model_reset();

        // Reset held for two edges.
        rst_n = 1'b0;
        step();
        step();
        chk("rst_trigger", 32'(trigger), 32'(0));
        chk("rst_evt", 32'(evt_cnt), 32'(0));
        rst_n = 1'b1;

        // One-shot, run_len 3, pulses of 1, 2, 3 and 5 with single-cycle gaps.
        run_len = CNT_W'(3);
        mode    = 1'b0;
        foreach (lens[p]) begin
            for (int e = 1; e <= lens[p]; e++) begin
                ena[0] = 1'b1;
                step();
                chk("os_trig0", 32'(trigger[0]), 32'(e == 3));
            end
            ena[0] = 1'b0;
            step();
        end
        chk("os_evt", 32'(evt_cnt), 32'(2));

        // Periodic, run_len 3, ch1 held for 10 edges.
        mode = 1'b1;
        clear_evt();
        for (int e = 1; e <= 10; e++) begin
            ena[1] = 1'b1;
            step();
            chk("per_trig1", 32'(trigger[1]), 32'((e % 3) == 0));
        end
        ena = '0;
        step();
        chk("per_evt", 32'(evt_cnt), 32'(3));

        // One-shot saturation, run_len 15, ch2 held for 40 edges.
        mode    = 1'b0;
        run_len = CNT_W'(15);
        clear_evt();
        for (int e = 1; e <= 40; e++) begin
            ena[2] = 1'b1;
            step();
            chk("sat_trig2", 32'(trigger[2]), 32'(e == 15));
        end
        ena = '0;
        step();
        chk("sat_evt", 32'(evt_cnt), 32'(1));

        // All channels rise together, run_len 2.
        run_len = CNT_W'(2);
        clear_evt();
        ena = '1;
        step();
        step();
        chk("sim_trig", 32'(trigger), 32'({N_CH{1'b1}}));
        chk("sim_any", 32'(any_trigger), 32'(1));
        chk("sim_evt", 32'(evt_cnt), 32'(4));
        ena = '0;
        step();

        // Clear in the same cycle as two channels trigger.
        ena = 4'b0011;
        step();
        evt_clr = 1'b1;
        step();
        evt_clr = 1'b0;
        chk("clr_evt", 32'(evt_cnt), 32'(2));
        ena = '0;
        step();

        // Asynchronous reset mid-run.
        run_len = CNT_W'(3);
        ena[0]  = 1'b1;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_trig", 32'(trigger), 32'(0));
        chk("arst_any", 32'(any_trigger), 32'(0));
        chk("arst_evt", 32'(evt_cnt), 32'(0));
        step();
        step();
        rst_n = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            step();
            chk("arst_restart", 32'(trigger[0]), 32'(e == 3));
        end
        ena = '0;
        step();

        // run_len 0: nothing may ever fire.
        run_len = '0;
        for (int c = 0; c < 40; c++) begin
            ena  = N_CH'($urandom_range(0, (1 << N_CH) - 1));
            mode = 1'($urandom_range(0, 1));
            step();
            chk("rl0_trig", 32'(trigger), 32'(0));
        end
        ena = '0;
        step();

        // run_len 1 periodic: continuous trigger while held.
        run_len = CNT_W'(1);
        mode    = 1'b1;
        clear_evt();
        for (int e = 1; e <= 4; e++) begin
            ena[0] = 1'b1;
            step();
            chk("rl1_trig0", 32'(trigger[0]), 32'(1));
        end
        chk("rl1_evt", 32'(evt_cnt), 32'(4));
        ena = '0;
        step();

        // Randomized traffic; run_len only moves on an all-low edge.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 24) == 0) begin
                ena     = '0;
                run_len = ($urandom_range(0, 3) == 0) ? CNT_W'($urandom_range(0, CMAX))
                                                      : CNT_W'($urandom_range(0, 5));
            end else begin
                for (int i = 0; i < N_CH; i++) begin
                    if (ena[i]) begin
                        if ($urandom_range(0, 9) == 0) ena[i] = 1'b0;
                    end else if ($urandom_range(0, 1) == 0) begin
                        ena[i] = 1'b1;
                    end
                end
            end
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            evt_clr = ($urandom_range(0, 31) == 0);
            step();
        end
        evt_clr = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
